// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache <-> main-memory line interface.
package cache_pkg;
    localparam int LINE_ADDR_LEN_DEFAULT = 3;
    localparam int LINE_SIZE = 2 ** LINE_ADDR_LEN_DEFAULT;

    typedef logic [31:0] word_t;
    typedef word_t line_t [LINE_SIZE];

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_DONE
    } mem_state_t;
endpackage

// File: rtl/line_mem_array.sv
// Single-port line storage: synchronous write, synchronous read into a held output register.
module line_mem_array #(
    parameter int ADDR_LEN  = 10,
    parameter int LINE_BITS = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic [ADDR_LEN-1:0]  i_addr,
    input  logic [LINE_BITS-1:0] i_wdata,
    output logic [LINE_BITS-1:0] o_rdata
);
    localparam int DEPTH = 2 ** ADDR_LEN;

    // Storage is deliberately outside reset so contents survive an aborted request.
    logic [LINE_BITS-1:0] r_mem [DEPTH];
    logic [LINE_BITS-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/line_mem_responder.sv
// Slow line-granular memory responder: accepts one line read/write, waits LATENCY cycles, pulses gnt.
module line_mem_responder
    import cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEFAULT,
    parameter int ADDR_LEN      = 10,
    parameter int LATENCY       = 50
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [ADDR_LEN-1:0]                addr,
    input  logic                               rd_req,
    input  logic                               wr_req,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]   wr_line,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]   rd_line,
    output logic                               gnt
);
    localparam int LINE_BITS = 32 * (2 ** LINE_ADDR_LEN);
    localparam int CNT_W     = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_t            r_state;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_LEN-1:0]   r_addr;
    logic                  r_isWrite;
    logic [LINE_BITS-1:0]  r_wrLine;
    logic                  r_gnt;

    logic w_finish;
    logic w_we;
    logic w_re;

    // The array access happens on the edge entering DONE; a reset on that edge aborts it.
    assign w_finish = rst_n && (r_state == MEM_BUSY) && (r_count == '0);
    assign w_we     = w_finish && r_isWrite;
    assign w_re     = w_finish && !r_isWrite;
    assign gnt      = r_gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= MEM_IDLE;
            r_count   <= '0;
            r_addr    <= '0;
            r_isWrite <= 1'b0;
            r_wrLine  <= '0;
            r_gnt     <= 1'b0;
        end else begin
            r_gnt <= 1'b0;
            case (r_state)
                MEM_IDLE: begin
                    if (wr_req || rd_req) begin
                        r_addr    <= addr;
                        r_isWrite <= wr_req;
                        r_wrLine  <= wr_line;
                        r_count   <= CNT_LOAD;
                        r_state   <= MEM_BUSY;
                    end
                end
                MEM_BUSY: begin
                    if (r_count == '0) begin
                        r_state <= MEM_DONE;
                        r_gnt   <= 1'b1;
                    end else begin
                        r_count <= r_count - CNT_ONE;
                    end
                end
                MEM_DONE: begin
                    r_state <= MEM_IDLE;
                end
                default: begin
                    r_state <= MEM_IDLE;
                end
            endcase
        end
    end

    line_mem_array #(
        .ADDR_LEN  (ADDR_LEN),
        .LINE_BITS (LINE_BITS)
    ) u_array (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (r_addr),
        .i_wdata (r_wrLine),
        .o_rdata (rd_line)
    );
endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench: directed vector table, hand-written corner sequences and random traffic vs a line-array model.
module tb_line_mem_responder;
    import cache_pkg::*;

    localparam int LAT = 4;
    localparam int AW  = 10;
    localparam int LB  = 32 * LINE_SIZE;

    typedef logic [LB-1:0] flat_t;

    typedef struct {
        bit            isWr;
        logic [AW-1:0] addr;
        flat_t         data;
        flat_t         expRd;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic          rd_req;
    logic          wr_req;
    flat_t         wr_line;
    flat_t         rd_line;
    logic          gnt;

    logic [AW-1:0] addr1;
    logic          rdReq1;
    logic          wrReq1;
    flat_t         wrLine1;
    flat_t         rdLine1;
    logic          gnt1;

    int    cycNo = 0;
    int    nTests = 0;
    int    nFail = 0;
    flat_t model [1024];
    flat_t expRd;
    vec_t  vecs [4];

    always #5 clk = ~clk;
    always @(posedge clk) cycNo <= cycNo + 1;

    line_mem_responder #(
        .LINE_ADDR_LEN (3),
        .ADDR_LEN      (AW),
        .LATENCY       (LAT)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .wr_line (wr_line),
        .rd_line (rd_line),
        .gnt     (gnt)
    );

    line_mem_responder #(
        .LINE_ADDR_LEN (3),
        .ADDR_LEN      (AW),
        .LATENCY       (1)
    ) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr1),
        .rd_req  (rdReq1),
        .wr_req  (wrReq1),
        .wr_line (wrLine1),
        .rd_line (rdLine1),
        .gnt     (gnt1)
    );

    function automatic flat_t mkLine(input logic [31:0] base);
        flat_t r;
        r = '0;
        for (int i = 0; i < LINE_SIZE; i++) r[32*i +: 32] = base + 32'(i);
        return r;
    endfunction

    function automatic flat_t fillLine(input logic [31:0] w);
        flat_t r;
        r = '0;
        for (int i = 0; i < LINE_SIZE; i++) r[32*i +: 32] = w;
        return r;
    endfunction

    task automatic checkOutput(input string name, input flat_t actual, input flat_t expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issues one request in the cycle after the previous gnt; returns latency and gnt cycle number.
    task automatic applyStimulus(input bit isWr, input logic [AW-1:0] a, input flat_t d,
                                 input bit corrupt, output int lat, output int gntCyc);
        @(posedge clk); #1;
        checkOutput("gnt low when idle", flat_t'(gnt), '0);
        addr    = a;
        wr_line = d;
        wr_req  = isWr;
        rd_req  = !isWr;
        lat     = 0;
        gntCyc  = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (k == 1 && corrupt) begin
                addr    = 10'h3FF;
                wr_line = fillLine(32'hDEAD);
            end
            if (gnt) begin
                lat    = k;
                gntCyc = cycNo;
                break;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        if (gntCyc < 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL gnt timeout: got no gnt, expected gnt after %0d cycles", LAT + 1);
        end
    endtask

    task automatic runOp(input bit isWr, input logic [AW-1:0] a, input flat_t d,
                         input bit corrupt, input string name, output int gntCyc);
        int lat;
        applyStimulus(isWr, a, d, corrupt, lat, gntCyc);
        checkOutput({name, " latency"}, flat_t'(lat), flat_t'(LAT + 1));
        if (isWr) model[a] = d;
        else      expRd = model[a];
        checkOutput({name, " rd_line"}, rd_line, expRd);
    endtask

    task automatic waitGnt1(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (gnt1) begin
                lat = k;
                break;
            end
        end
        rdReq1 = 1'b0;
        wrReq1 = 1'b0;
    endtask

    initial begin
        int   gc1;
        int   gc2;
        int   lat1;
        bit   sawGnt;
        logic [AW-1:0] pool [8];
        flat_t rnd;

        rst_n   = 1'b0;
        addr    = 10'h005;
        rd_req  = 1'b1;
        wr_req  = 1'b0;
        wr_line = '0;
        addr1   = '0;
        rdReq1  = 1'b0;
        wrReq1  = 1'b0;
        wrLine1 = '0;
        expRd   = '0;
        for (int i = 0; i < 1024; i++) model[i] = '0;

        vecs[0] = '{isWr: 1'b0, addr: 10'h005, data: '0, expRd: '0};
        vecs[1] = '{isWr: 1'b1, addr: 10'h1A3, data: mkLine(32'hA0), expRd: '0};
        vecs[2] = '{isWr: 1'b0, addr: 10'h1A3, data: '0, expRd: mkLine(32'hA0)};
        vecs[3] = '{isWr: 1'b0, addr: 10'h1A4, data: '0, expRd: '0};

        // Reset held with a pending read: nothing may complete.
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("reset gnt", flat_t'(gnt), '0);
            checkOutput("reset rd_line", rd_line, '0);
        end
        rst_n  = 1'b1;
        rd_req = 1'b0;

        for (int v = 0; v < 4; v++) begin
            runOp(vecs[v].isWr, vecs[v].addr, vecs[v].data, 1'b0, $sformatf("vec%0d", v), gc1);
            checkOutput($sformatf("vec%0d table rd_line", v), rd_line, vecs[v].expRd);
        end

        // Back-to-back write then read, second request issued right after the first gnt.
        runOp(1'b1, 10'h010, mkLine(32'h1000), 1'b0, "b2b write", gc1);
        runOp(1'b0, 10'h020, '0, 1'b0, "b2b read", gc2);
        checkOutput("b2b gnt spacing", flat_t'(gc2 - gc1), flat_t'(LAT + 2));
        runOp(1'b0, 10'h010, '0, 1'b0, "b2b readback", gc1);
        checkOutput("b2b readback data", rd_line, mkLine(32'h1000));

        // Inputs disturbed while busy must not affect the latched request.
        runOp(1'b1, 10'h001, mkLine(32'h1234_0000), 1'b1, "stable write", gc1);
        checkOutput("stable write keeps rd_line", rd_line, mkLine(32'h1000));
        runOp(1'b0, 10'h001, '0, 1'b0, "stable read 001", gc1);
        checkOutput("stable 001 data", rd_line, mkLine(32'h1234_0000));
        runOp(1'b0, 10'h3FF, '0, 1'b0, "stable read 3FF", gc1);
        checkOutput("stable 3FF untouched", rd_line, '0);

        // Reset in the middle of a write aborts it.
        @(posedge clk); #1;
        addr    = 10'h040;
        wr_line = fillLine(32'h5555_5555);
        wr_req  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        wr_req = 1'b0;
        checkOutput("abort rd_line cleared", rd_line, '0);
        expRd  = '0;
        sawGnt = 1'b0;
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            if (gnt) sawGnt = 1'b1;
        end
        checkOutput("abort no gnt", flat_t'(sawGnt), '0);
        runOp(1'b0, 10'h040, '0, 1'b0, "abort readback", gc1);
        checkOutput("abort 040 still zero", rd_line, '0);

        // Random traffic over a small address pool against the array model.
        pool = '{10'h005, 10'h1A3, 10'h1A4, 10'h010, 10'h020, 10'h001, 10'h3FF, 10'h040};
        for (int n = 0; n < 30; n++) begin
            rnd = '0;
            for (int i = 0; i < LINE_SIZE; i++) rnd[32*i +: 32] = $urandom;
            runOp(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], rnd, 1'b0,
                  $sformatf("rand%0d", n), gc1);
        end

        // LATENCY=1 instance with both requests high: write wins.
        @(posedge clk); #1;
        addr1   = 10'h077;
        wrLine1 = mkLine(32'hC0);
        rdReq1  = 1'b1;
        wrReq1  = 1'b1;
        waitGnt1(lat1);
        checkOutput("lat1 both-req latency", flat_t'(lat1), flat_t'(2));
        checkOutput("lat1 write leaves rd_line", rdLine1, '0);
        @(posedge clk); #1;
        checkOutput("lat1 gnt single pulse", flat_t'(gnt1), '0);
        rdReq1 = 1'b1;
        waitGnt1(lat1);
        checkOutput("lat1 read latency", flat_t'(lat1), flat_t'(2));
        checkOutput("lat1 read data", rdLine1, mkLine(32'hC0));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
